// File: rtl/dcache_pkg.sv
// dcache_pkg: AXI channel payload structs, fixed burst encodings, bridge FSM
// state encoding and the line-alignment helper for the dCache AXI bridge.
package dcache_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        valid;
   } axi_ar_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        valid;
   } axi_aw_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        valid;
   } axi_r_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      logic        valid;
   } axi_w_t;

   typedef struct packed {
      logic [1:0] resp;
      logic       valid;
   } axi_b_t;

   // Encoding source for the bridge FSM; the top keeps plain logic constants.
   typedef enum logic [2:0] {
      BS_IDLE    = 3'd0,
      BS_RD_ADDR = 3'd1,
      BS_RD_DATA = 3'd2,
      BS_WR_ADDR = 3'd3,
      BS_WR_DATA = 3'd4,
      BS_WR_RESP = 3'd5
   } bridge_state_t;

   // Clear the byte-in-line offset bits of an address.
   function automatic logic [31:0] line_align(input logic [31:0] addr,
                                              input int unsigned line_words);
      logic [31:0] mask;
      mask = ~((32'(line_words) * 32'd4) - 32'd1);
      return addr & mask;
   endfunction

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// dcache_axi_bridge_if: the five AXI4 channels between the bridge (master)
// and the memory system (slave).
interface dcache_axi_bridge_if;
   import dcache_pkg::*;

   axi_ar_t ar_req;
   logic    ar_ready;
   axi_r_t  r_in;
   logic    r_ready;
   axi_aw_t aw_req;
   logic    aw_ready;
   axi_w_t  w_req;
   logic    w_ready;
   axi_b_t  b_in;
   logic    b_ready;

   modport master (
      output ar_req, r_ready, aw_req, w_req, b_ready,
      input  ar_ready, r_in, aw_ready, w_ready, b_in
   );

   modport slave (
      input  ar_req, r_ready, aw_req, w_req, b_ready,
      output ar_ready, r_in, aw_ready, w_ready, b_in
   );

endinterface

// File: rtl/dcache_wbeat_buf.sv
// dcache_wbeat_buf: one-entry valid/ready register for the AXI W channel.
// Fills only while empty and drains on a handshake, so a capture and a drain
// never share a cycle (at most one beat every two cycles, no bypass).
module dcache_wbeat_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready
);

   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;

   // Next-state: drain when full and accepted, otherwise fill when empty.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q) begin
         if (out_ready) begin
            valid_d = 1'b0;
         end
      end else if (in_valid) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end
   end

   // Occupancy flag with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload register.
   always_ff @(posedge clk) begin
      // NOTE: the payload is deliberately not reset; valid_q alone qualifies it.
      data_q <= data_d;
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: converts the dCache controller's word-at-a-time
// req/addr_ok/data_ok handshake into one AXI4 INCR burst per cache line
// (read burst for a refill, write burst plus response for a write-back).
// Optional feature macro: DCACHE_BRIDGE_ERR_EN -- when defined, bus_err is a
// sticky flag for non-OKAY R/B responses and R last/counter mismatches;
// when undefined, bus_err is tied low and resp/last are ignored.
module dcache_axi_bridge
   import dcache_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_req,
   input  logic                       mem_we,
   input  logic                       mem_wstart,
   input  logic [31:0]                mem_addr,
   input  logic [31:0]                mem_wdata,
   output logic                       mem_addr_ok,
   output logic                       mem_data_ok,
   output logic [31:0]                mem_rdata,
   output logic                       wb_ok,
   output logic                       bus_err,
   dcache_axi_bridge_if.master        axi
);

   localparam int unsigned   CW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
   localparam logic [7:0]    AXI_LEN   = 8'(LINE_WORDS - 1);

   // Legacy-compatible state constants taken from the shared encoding.
   localparam logic [2:0] IDLE    = BS_IDLE;
   localparam logic [2:0] RD_ADDR = BS_RD_ADDR;
   localparam logic [2:0] RD_DATA = BS_RD_DATA;
   localparam logic [2:0] WR_ADDR = BS_WR_ADDR;
   localparam logic [2:0] WR_DATA = BS_WR_DATA;
   localparam logic [2:0] WR_RESP = BS_WR_RESP;

   logic [2:0]    state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          wbuf_in_valid;
   logic          wbuf_out_valid;
   logic [31:0]   wbuf_out_data;
   logic          w_fire;
   logic          r_fire;
   logic          b_fire;
   logic          last_beat;

   assign last_beat = (cnt_q == LAST_BEAT);
   assign r_fire    = (state_q == RD_DATA) && axi.r_in.valid;
   assign w_fire    = wbuf_out_valid && axi.w_ready;
   assign b_fire    = (state_q == WR_RESP) && axi.b_in.valid;

   // Controller write words are only taken during the data phase of a write-back.
   assign wbuf_in_valid = (state_q == WR_DATA) && mem_req;

   dcache_wbeat_buf u_wbeat_buf (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (wbuf_in_valid),
      .in_data   (mem_wdata),
      .out_valid (wbuf_out_valid),
      .out_data  (wbuf_out_data),
      .out_ready (axi.w_ready)
   );

   // FSM next-state, latched line address and beat counter.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (mem_req && !mem_we) begin
               addr_d  = line_align(mem_addr, LINE_WORDS);
               state_d = RD_ADDR;
            end else if (mem_req && mem_we && mem_wstart) begin
               addr_d  = line_align(mem_addr, LINE_WORDS);
               state_d = WR_ADDR;
            end
         end
         RD_ADDR: begin
            if (axi.ar_ready) begin
               cnt_d   = '0;
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            // The counter, not r.last, decides when the burst is over.
            if (r_fire) begin
               cnt_d = cnt_q + CW'(1);
               if (last_beat) begin
                  state_d = IDLE;
               end
            end
         end
         WR_ADDR: begin
            if (axi.aw_ready) begin
               cnt_d   = '0;
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            if (w_fire) begin
               cnt_d = cnt_q + CW'(1);
               if (last_beat) begin
                  state_d = WR_RESP;
               end
            end
         end
         WR_RESP: begin
            if (b_fire) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and beat counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Line address register; only meaningful while a burst is in flight.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
   end

`ifdef DCACHE_BRIDGE_ERR_EN
   logic err_q, err_d;

   // Sticky error: bad R/B response or r.last disagreeing with the counter.
   always_comb begin
      err_d = err_q;
      if (r_fire && ((axi.r_in.resp != AXI_RESP_OKAY) || (axi.r_in.last != last_beat))) begin
         err_d = 1'b1;
      end
      if (b_fire && (axi.b_in.resp != AXI_RESP_OKAY)) begin
         err_d = 1'b1;
      end
   end

   // Error flag clears only on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus_err = err_q;
`else
   // Response codes and r.last have no consumer when error reporting is off.
   logic unused_err_fields;
   assign unused_err_fields = ^{axi.r_in.resp, axi.r_in.last, axi.b_in.resp};
   assign bus_err = 1'b0;
`endif

   // Controller-side handshake pulses; rdata is a straight pass of the R beat.
   assign mem_addr_ok = ((state_q == RD_ADDR) && axi.ar_ready) ||
                        ((state_q == WR_ADDR) && axi.aw_ready);
   assign mem_data_ok = r_fire || w_fire;
   assign mem_rdata   = axi.r_in.data;
   assign wb_ok       = b_fire;

   // AXI channel drives; burst shape is fixed, only address and valid vary.
   assign axi.ar_req = '{addr:  addr_q,
                         len:   AXI_LEN,
                         size:  AXI_SIZE_4B,
                         burst: AXI_BURST_INCR,
                         valid: (state_q == RD_ADDR)};
   assign axi.aw_req = '{addr:  addr_q,
                         len:   AXI_LEN,
                         size:  AXI_SIZE_4B,
                         burst: AXI_BURST_INCR,
                         valid: (state_q == WR_ADDR)};
   assign axi.w_req  = '{data:  wbuf_out_data,
                         strb:  4'hF,
                         last:  last_beat,
                         valid: wbuf_out_valid};
   assign axi.r_ready = (state_q == RD_DATA);
   assign axi.b_ready = (state_q == WR_RESP);

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb_dcache_axi_bridge: directed self-checking bench for dcache_axi_bridge
// (LINE_WORDS = 8). Inputs change on the falling edge; outputs are sampled
// 1 time unit later, i.e. with the values the next rising edge will see.
module tb_dcache_axi_bridge;
   import dcache_pkg::*;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic        mem_wstart;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        wb_ok;
   logic        bus_err;

   dcache_axi_bridge_if bus ();

   dcache_axi_bridge #(.LINE_WORDS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_wstart  (mem_wstart),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata),
      .wb_ok       (wb_ok),
      .bus_err     (bus_err),
      .axi         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   logic exp_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_wstart   = 1'b0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      bus.ar_ready = 1'b0;
      bus.r_in     = '0;
      bus.aw_ready = 1'b0;
      bus.w_ready  = 1'b0;
      bus.b_in     = '0;
   endtask

   // All AXI valid/ready outputs low: the bridge is back in IDLE.
   task automatic check_idle(input string tag);
      check({tag, "_idle"},
            32'({bus.ar_req.valid, bus.aw_req.valid, bus.w_req.valid, bus.r_ready, bus.b_ready}),
            32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_err = 1'b0;
      check_idle("rst");
      check("rst_bus_err", 32'(bus_err), 32'h0);
   endtask

   // Refill of one line. ar_wait = cycles ar_ready stays low while ar.valid is
   // up; last_at = beat index carrying r.last; rst_at = beat index at which
   // reset is asserted (-1 for none). A one-cycle R gap precedes beat 2.
   task automatic run_refill(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [31:0] d0, input int ar_wait,
                             input int last_at, input int rst_at);
      int addr_oks = 0;
      @(negedge clk);
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = addr;
      #1;
      check("rf_no_ar_yet", 32'(bus.ar_req.valid), 32'h0);
      for (int n = 0; n <= ar_wait; n++) begin
         @(negedge clk);
         mem_addr     = 32'hDEAD_BEEF;
         bus.ar_ready = (n == ar_wait);
         #1;
         check("rf_ar_valid", 32'(bus.ar_req.valid), 32'h1);
         check("rf_ar_addr", bus.ar_req.addr, exp_addr);
         check("rf_addr_ok", 32'(mem_addr_ok), 32'(n == ar_wait));
         if (mem_addr_ok) addr_oks++;
      end
      check("rf_ar_shape", 32'({bus.ar_req.len, bus.ar_req.size, bus.ar_req.burst}),
            32'({8'd7, 3'b010, 2'b01}));
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            @(negedge clk);
            mem_req      = 1'b0;
            bus.ar_ready = 1'b0;
            bus.r_in     = '0;
            #1;
            check("rf_gap_data_ok", 32'(mem_data_ok), 32'h0);
            check("rf_gap_r_ready", 32'(bus.r_ready), 32'h1);
         end
         @(negedge clk);
         mem_req      = 1'b0;
         bus.ar_ready = 1'b0;
         bus.r_in     = '{data: d0 + 32'(k), resp: AXI_RESP_OKAY,
                          last: 1'(k == last_at), valid: 1'b1};
         if (k == rst_at) reset = 1'b1;
         #1;
         check("rf_r_ready", 32'(bus.r_ready), 32'h1);
         check("rf_data_ok", 32'(mem_data_ok), 32'h1);
         check("rf_rdata", mem_rdata, d0 + 32'(k));
         if (k == rst_at) begin
            @(negedge clk);
            reset = 1'b0;
            idle_inputs();
            #1;
            exp_err = 1'b0;
            check_idle("rf_mid_rst");
            check("rf_mid_rst_bus_err", 32'(bus_err), 32'h0);
            return;
         end
      end
`ifdef DCACHE_BRIDGE_ERR_EN
      if (last_at != 7) exp_err = 1'b1;
`endif
      @(negedge clk);
      bus.r_in = '0;
      #1;
      check_idle("rf_done");
      check("rf_addr_ok_count", 32'(addr_oks), 32'h1);
      check("rf_bus_err", 32'(bus_err), 32'(exp_err));
   endtask

   // Write-back of one line with words d0..d0+7; w_ready toggles randomly.
   task automatic run_wb(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] d0, input int aw_wait, input logic [1:0] bresp);
      int beats = 0;
      int cyc   = 0;
      @(negedge clk);
      mem_req    = 1'b1;
      mem_we     = 1'b1;
      mem_wstart = 1'b1;
      mem_addr   = addr;
      mem_wdata  = d0;
      #1;
      check("wb_no_aw_yet", 32'(bus.aw_req.valid), 32'h0);
      for (int n = 0; n <= aw_wait; n++) begin
         @(negedge clk);
         mem_wstart   = 1'b0;
         mem_addr     = 32'hDEAD_BEEF;
         bus.aw_ready = (n == aw_wait);
         #1;
         check("wb_aw_valid", 32'(bus.aw_req.valid), 32'h1);
         check("wb_aw_addr", bus.aw_req.addr, exp_addr);
         check("wb_addr_ok", 32'(mem_addr_ok), 32'(n == aw_wait));
         check("wb_w_quiet", 32'(bus.w_req.valid), 32'h0);
      end
      check("wb_aw_shape", 32'({bus.aw_req.len, bus.aw_req.size, bus.aw_req.burst}),
            32'({8'd7, 3'b010, 2'b01}));
      while (beats < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.aw_ready = 1'b0;
         mem_req      = 1'b1;
         mem_wdata    = d0 + 32'(beats);
         bus.w_ready  = 1'($urandom_range(0, 1));
         #1;
         if (bus.w_req.valid && bus.w_ready) begin
            check("wb_wdata", bus.w_req.data, d0 + 32'(beats));
            check("wb_wlast", 32'(bus.w_req.last), 32'(beats == 7));
            check("wb_wstrb", 32'(bus.w_req.strb), 32'hF);
            check("wb_data_ok", 32'(mem_data_ok), 32'h1);
            beats++;
         end else begin
            check("wb_no_data_ok", 32'(mem_data_ok), 32'h0);
         end
      end
      check("wb_beat_count", 32'(beats), 32'h8);
      @(negedge clk);
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      bus.w_ready = 1'b0;
      #1;
      check("wb_b_ready", 32'(bus.b_ready), 32'h1);
      check("wb_ok_early", 32'(wb_ok), 32'h0);
      @(negedge clk);
      bus.b_in = '{resp: bresp, valid: 1'b1};
      #1;
      check("wb_ok", 32'(wb_ok), 32'h1);
      @(negedge clk);
      bus.b_in = '0;
      #1;
      check("wb_ok_single", 32'(wb_ok), 32'h0);
      check_idle("wb_done");
`ifdef DCACHE_BRIDGE_ERR_EN
      if (bresp != AXI_RESP_OKAY) exp_err = 1'b1;
`endif
      check("wb_bus_err", 32'(bus_err), 32'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_idle("reset");
      check("reset_pulses", 32'({mem_addr_ok, mem_data_ok, wb_ok}), 32'h0);
      check("reset_bus_err", 32'(bus_err), 32'h0);

      // Basic refill, ar_ready on the second valid cycle.
      run_refill(32'h1000_0014, 32'h1000_0000, 32'h0000_00A0, 1, 7, -1);
      // Basic write-back, aw_ready on the first valid cycle.
      run_wb(32'h2000_0020, 32'h2000_0020, 32'h0000_00B0, 0, AXI_RESP_OKAY);
      // Address-channel backpressure.
      run_refill(32'h1000_0044, 32'h1000_0040, 32'h0000_00C0, 5, 7, -1);
      run_wb(32'h2000_005C, 32'h2000_0040, 32'h0000_00D0, 3, AXI_RESP_OKAY);

      // A write beat without wstart in IDLE starts nothing.
      @(negedge clk);
      mem_req    = 1'b1;
      mem_we     = 1'b1;
      mem_wstart = 1'b0;
      mem_addr   = 32'h5000_0000;
      @(negedge clk);
      idle_inputs();
      #1;
      check_idle("ignored_wbeat");

      // Reset on the 4th R beat, then a fresh refill.
      run_refill(32'h3000_0000, 32'h3000_0000, 32'h0000_00E0, 0, 7, 3);
      run_refill(32'h3000_0008, 32'h3000_0000, 32'h0000_00F0, 0, 7, -1);

      // SLVERR on B: wb_ok still pulses; error flag is sticky across a clean refill.
      run_wb(32'h4000_0000, 32'h4000_0000, 32'h0000_0100, 1, 2'b10);
      run_refill(32'h4000_0020, 32'h4000_0020, 32'h0000_0110, 0, 7, -1);
      do_reset();

      // Early r.last on beat 5: the counter still runs the full 8 beats.
      run_refill(32'h6000_001C, 32'h6000_0000, 32'h0000_0120, 1, 4, -1);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
